// File: rtl/rtc_seq_pkg.sv
// Shared definitions for the RTC bus sequencer: FSM state encoding, the
// register-index to bus-address table and the error data pattern.
package rtc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_TURN,
    ST_DATA,
    ST_RECOV
  } seq_state_e;

  localparam int N_REGS_MAX = 13;

  localparam logic [7:0] ERR_DATA = 8'hFF;

  // init, zero, status, command, sec, min, hour, day, month, year,
  // timer sec, timer min, timer hour
  localparam logic [7:0] ADDR_TABLE [N_REGS_MAX] = '{
    8'h10, 8'h00, 8'h02, 8'hF0, 8'h21, 8'h22, 8'h23,
    8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43
  };

  // Table lookup with constant indices only; out-of-range yields 0.
  function automatic logic [7:0] table_addr(input int idx);
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < N_REGS_MAX; i++) begin
      if (idx == i) a = ADDR_TABLE[i];
    end
    return a;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times one bus phase; done is high while the
// count sits at zero, i.e. on the last cycle of the phase.
module rtc_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequenced register-access engine for the RTC multiplexed address/data bus.
// Runs ADDR -> TURN -> DATA -> RECOV per access, each phase PHASE_CYC cycles.
// Optional feature macro: RTC_SEQ_READBACK_EN (verify each write by reading
// the same address back and flag a mismatch in rsp_err).
module rtc_bus_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4,
  parameter int N_REGS    = 13,
  parameter int PHASE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              ad_sel,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYC - 1);

  seq_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic              rb_q, rb_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;
  logic              ad_sel_q, ad_sel_d;
  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;

  logic phase_done;
  logic phase_load;
  logic rsp_now;
  logic bus_wr_d;

  // Every state change starts a fresh phase.
  assign phase_load = (state_d != state_q);

  rtc_phase_timer #(
    .WIDTH (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (phase_load),
    .load_val (PHASE_LOAD),
    .done     (phase_done)
  );

  // Next-state, request latching, read capture and response generation.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    rb_d        = rb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_now     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          wdata_d = req_wdata;
          rb_d    = 1'b0;
          if (int'(req_idx) < N_REGS) begin
            addr_d  = DATA_W'(table_addr(int'(req_idx)));
            state_d = ST_ADDR;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = DATA_W'(ERR_DATA);
          end
        end
      end
      ST_ADDR: begin
        if (phase_done) state_d = ST_TURN;
      end
      ST_TURN: begin
        if (phase_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (phase_done) begin
          state_d = ST_RECOV;
          if (!(write_q && !rb_q)) rdata_d = ad_in;
        end
      end
      ST_RECOV: begin
        if (phase_done) begin
          state_d = ST_IDLE;
          rsp_now = 1'b1;
`ifdef RTC_SEQ_READBACK_EN
          if (write_q && !rb_q) begin
            rb_d    = 1'b1;
            state_d = ST_ADDR;
            rsp_now = 1'b0;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rsp_now) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (write_q && !rb_q) ? wdata_q : rdata_q;
      rsp_err_d   = rb_q && (rdata_q != wdata_q);
    end
  end

  // Bus pin values for the phase being entered, so the pins are registered.
  always_comb begin
    bus_wr_d    = write_d && !rb_d;
    req_ready_d = (state_d == ST_IDLE);
    cs_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    ad_sel_d    = 1'b0;
    ad_oe_d     = 1'b0;
    ad_out_d    = ad_out_q;

    case (state_d)
      ST_ADDR: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      ST_TURN: begin
        cs_n_d  = 1'b0;
        ad_oe_d = bus_wr_d;
      end
      ST_DATA: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        if (bus_wr_d) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // State, transaction context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      rb_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      ad_sel_q    <= 1'b0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      rb_q        <= rb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      ad_sel_q    <= ad_sel_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign rd_n      = rd_n_q;
  assign ad_sel    = ad_sel_q;
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequenced register-access engine for the external RTC's multiplexed address/data bus. It replaces the fixed one-hot address decoder with a parametrised, handshaked block. A request names a register index, and the block looks the index up in a shared address table. It then drives the complete bus cycle: chip select, address phase, turnaround, data phase and recovery. It returns read data or an error. It sits between the controller FSM and the RTC pins.

## Interface
- `DATA_W`, 8: bus and data width (≥8); table addresses zero-extended.
- `IDX_W`, 4: register index width.
- `N_REGS`, 13: number of valid indices (≤13, the table size).
- `PHASE_CYC`, 4: clock cycles per bus phase (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_idx`  in  IDX_W  register index.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  DATA_W  read or readback data; 8'hFF on error.
- `rsp_err`  out  1  invalid index, or readback mismatch.
- `cs_n`, `wr_n`, `rd_n`  out  1 each  RTC strobes, active low.
- `ad_sel`  out  1  0 = address phase, 1 = data phase.
- `ad_out`  out  DATA_W  bus drive value.
- `ad_oe`  out  1  pad output enable.
- `ad_in`  in  DATA_W  bus sampled value.

## Operation
- Address table, by index 0–12: 0x10, 0x00, 0x02, 0xF0, 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43. These are init, zero, status, command, sec, min, hour, day, month, year, timer sec, timer min, timer hour.
- A request is accepted on `req_valid & req_ready`. The block latches idx, write and wdata.
- If idx ≥ N_REGS, no bus activity occurs: the block returns `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=FF` on the next cycle and stays in IDLE.
- FSM: IDLE → ADDR → TURN → DATA → RECOV → IDLE. Each non-IDLE state lasts exactly PHASE_CYC cycles.
- ADDR: `cs_n=0`, `ad_sel=0`, `ad_oe=1`, `ad_out`=table address, `wr_n=0`.
- TURN: `cs_n=0`, all strobes high. `ad_oe` is held at 1 for a write and 0 for a read.
- DATA, write: `ad_sel=1`, `ad_oe=1`, `ad_out=wdata`, `wr_n=0`.
- DATA, read: `ad_sel=1`, `ad_oe=0`, `rd_n=0`. `ad_in` is captured on the last DATA cycle.
- RECOV: `cs_n=1`, strobes high, `ad_oe=0`.
- On RECOV exit the FSM returns to IDLE and pulses `rsp_valid` in that same cycle. `rsp_rdata` holds the captured data for a read, or wdata for a write; `rsp_err=0`.
- `rsp_rdata` and `rsp_err` hold until the next response.
- `wr_n` and `rd_n` are never low simultaneously. `cs_n` is high whenever both are high outside ADDR through DATA.

## Timing
- All outputs are registered. Reset values:
  - `cs_n`, `wr_n`, `rd_n` = 1
  - `ad_sel`, `ad_oe`, `rsp_valid`, `rsp_err` = 0
  - `ad_out`, `rsp_rdata` = 0
  - `req_ready` = 1
- Acceptance is at cycle T. ADDR occupies T+1 … T+P, where P = PHASE_CYC. `rsp_valid` fires at T+4P+1, and `req_ready` is high in that same cycle.
- Back-to-back requests: the next request may be accepted in the `rsp_valid` cycle.
- Requests presented while `req_ready=0` are ignored, not queued.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously) and the state returns to IDLE. No `rsp_valid` is issued for the aborted request.
- The phase counter is ⌈log2(PHASE_CYC)⌉ bits wide, minimum 1, and reloads on every state entry.

## Configuration
- Macro `RTC_SEQ_READBACK_EN`.
- Defined: after the RECOV of a write, the block runs a full read cycle (ADDR through RECOV) to the same address. The response then carries the readback data, with `rsp_err` = (readback ≠ wdata). Write latency becomes 8P+1.
- Undefined: no readback. Write latency is 4P+1, and `rsp_err` is only set for an invalid index.

## Structure
- Package `rtc_seq_pkg` holds:
  - the state enum;
  - `ADDR_TABLE`, a 13-entry, 8-bit constant;
  - `N_REGS_MAX = 13`;
  - `ERR_DATA = 8'hFF`.
- Sub-module `rtc_phase_timer`: a loadable down-counter with a `done` output. It is instantiated once.

## Test plan
- P=4, write idx 4 with data 0x59. Required: `ad_out=0x21` with `wr_n=0` for cycles T+1…T+4. Then `ad_out=0x59` with `wr_n=0` for T+9…T+12. Then `rsp_valid` at T+17 with `rsp_err=0`.
- Read idx 12 with `ad_in=0x23` during DATA. Required: `ad_out=0x43` in ADDR, `rd_n` low for 4 cycles, `rsp_rdata=0x23`.
- Request idx 13. Required: `cs_n` stays 1, then `rsp_valid` at T+1 with `rsp_err=1` and `rsp_rdata=0xFF`.
- Hold `req_valid` high for two reads. Required: the second is accepted in the same cycle as the first `rsp_valid`, and there is no idle gap beyond RECOV.
- Assert `rst_n=0` mid-DATA of a write. Required: `wr_n` and `cs_n` go to 1 immediately, no `rsp_valid` is issued, and `req_ready=1` after release.
- With `RTC_SEQ_READBACK_EN`, write 0x59 while the model returns 0x58. Required: a second bus cycle is observed, then `rsp_rdata=0x58` and `rsp_err=1` at T+33.
